// File: rtl/sfifo_sync_flags_if.sv
// +------------------------------------------------------------------+
// | sfifo_sync_flags_if : write/read/status bundle for sfifo_sync_flags |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

interface sfifo_sync_flags_if #(
  parameter int DWIDTH = 8,
  parameter int PWIDTH = 8
);
  logic [DWIDTH-1:0] din;
  logic              push;
  logic              pop;
  logic              clr_err;
  logic [DWIDTH-1:0] dout;
  logic              dout_valid;
  logic              not_full;
  logic [PWIDTH:0]   count;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output din, push, pop, clr_err,
    input  dout, dout_valid, not_full, count,
    input  almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  din, push, pop, clr_err,
    output dout, dout_valid, not_full, count,
    output almost_full, almost_empty, overflow, underflow
  );
endinterface

`default_nettype wire

// File: rtl/sfifo_sync_flags.sv
// +------------------------------------------------------------------+
// | sfifo_sync_flags : single-clock FIFO, registered or FWFT read,     |
// | occupancy count, almost flags, sticky overflow/underflow. rev 1.0  |
// +------------------------------------------------------------------+
`default_nettype none

module sfifo_sync_flags #(
  parameter int DWIDTH   = 8,
  parameter int PWIDTH   = 8,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = 2**PWIDTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  wire logic         clk,
  input  wire logic         reset,
  sfifo_sync_flags_if.slave bus
);

  localparam int              DEPTH     = 2**PWIDTH;
  localparam logic [PWIDTH:0] DEPTH_CNT = (PWIDTH+1)'(DEPTH);
  localparam logic [PWIDTH:0] AF_CNT    = (PWIDTH+1)'(AF_LEVEL);
  localparam logic [PWIDTH:0] AE_CNT    = (PWIDTH+1)'(AE_LEVEL);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [PWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PWIDTH:0]   count_q, count_d;
  logic [DWIDTH-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              pop_ok;
  logic              push_ok;
  logic              mem_we;
  logic              mem_re;
  logic              load;
  logic              bypass;
  logic [PWIDTH:0]   mem_cnt;

  always_comb begin
    pop_ok       = 1'b0;
    push_ok      = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    load         = 1'b0;
    bypass       = 1'b0;
    mem_cnt      = count_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;

    if (FWFT != 0) begin
      pop_ok  = bus.pop & dout_valid_q;
      push_ok = bus.push & ((count_q != DEPTH_CNT) | pop_ok);
      // The output register is part of the count; memory holds the rest.
      mem_cnt = count_q - {{PWIDTH{1'b0}}, dout_valid_q};
      load    = ~dout_valid_q | pop_ok;
      mem_re  = load & (mem_cnt != '0);
      bypass  = load & (mem_cnt == '0) & push_ok;
      mem_we  = push_ok & ~bypass;
      if (load) begin
        if (mem_re) begin
          dout_d       = mem_q[rd_ptr_q];
          dout_valid_d = 1'b1;
        end else if (bypass) begin
          dout_d       = bus.din;
          dout_valid_d = 1'b1;
        end else begin
          dout_valid_d = 1'b0;
        end
      end
    end else begin
      pop_ok       = bus.pop & (count_q != '0);
      push_ok      = bus.push & ((count_q != DEPTH_CNT) | pop_ok);
      mem_re       = pop_ok;
      mem_we       = push_ok;
      dout_valid_d = pop_ok;
      if (mem_re) begin
        dout_d = mem_q[rd_ptr_q];
      end
    end

    wr_ptr_d = mem_we ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = mem_re ? rd_ptr_q + 1'b1 : rd_ptr_q;

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A fresh error in the clearing cycle keeps the flag set.
    overflow_d  = (overflow_q  & ~bus.clr_err) | (bus.push & ~push_ok);
    underflow_d = (underflow_q & ~bus.clr_err) | (bus.pop  & ~pop_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage is not reset; the read above sees the pre-write word.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[wr_ptr_q] <= bus.din;
    end
  end

  assign bus.dout         = dout_q;
  assign bus.dout_valid   = dout_valid_q;
  assign bus.count        = count_q;
  assign bus.not_full     = (count_q != DEPTH_CNT);
  assign bus.almost_full  = (count_q >= AF_CNT);
  assign bus.almost_empty = (count_q <= AE_CNT);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

`default_nettype wire
